// File: rtl/deck_shuffler_if.sv
// Load interface between the deck shuffler (master) and the game controller (slave).
// Controller requests a shuffle; the shuffler streams card codes back.
interface deck_shuffler_if ();
  logic       shuffle_flag;
  logic       load_flag;
  logic [5:0] card;
  logic       card_strobe;
  logic       busy;
  logic       done;

  modport master (
    input  shuffle_flag,
    output load_flag,
    output card,
    output card_strobe,
    output busy,
    output done
  );

  modport slave (
    output shuffle_flag,
    input  load_flag,
    input  card,
    input  card_strobe,
    input  busy,
    input  done
  );
endinterface

// File: rtl/deck_shuffler.sv
// Fisher-Yates shuffle of a 52-card deck driven by a free-running LFSR, then a paced card stream.
// Start to first card 53 cycles, to done 53+52*HOLD; no backpressure, the consumer follows card_strobe.
module deck_shuffler #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int unsigned HOLD = 2
) (
  input  logic            clk,
  input  logic            rst,
  deck_shuffler_if.master ld_if
);

  typedef enum logic [2:0] {IDLE, INIT, SHUFFLE, STREAM, DONE} state_e;

  localparam int          NCARDS    = 52;
  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [3:0]  HOLD_LAST = 4'(HOLD - 1);

  state_e      state_q;
  logic [5:0]  deck_q [NCARDS];
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        sf_q;
  logic        start;
  logic [5:0]  i_q;
  logic [5:0]  k_q;
  logic [5:0]  j;
  logic [3:0]  hold_cnt_q;
  logic        load_flag_q;
  logic        busy_q;
  logic        done_q;
  logic        card_strobe_q;
  logic [5:0]  card_q;

  assign start  = ld_if.shuffle_flag & ~sf_q;
  assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
  // Scaling the LFSR by (i+1) and keeping the top bits gives 0 <= j <= i without a divider.
  assign j = 6'((22'(lfsr_q) * 22'(i_q + 6'd1)) >> 16);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      lfsr_q        <= LFSR_INIT;
      sf_q          <= 1'b0;
      i_q           <= 6'd0;
      k_q           <= 6'd0;
      hold_cnt_q    <= 4'd0;
      load_flag_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      card_strobe_q <= 1'b0;
      card_q        <= 6'd63;
      for (int n = 0; n < NCARDS; n++) deck_q[n] <= 6'd0;
    end else begin
      lfsr_q        <= lfsr_d;
      sf_q          <= ld_if.shuffle_flag;
      card_strobe_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= INIT;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            card_q  <= 6'd63;
          end
        end
        INIT: begin
          for (int n = 0; n < NCARDS; n++) deck_q[n] <= 6'(n);
          i_q     <= 6'd51;
          state_q <= SHUFFLE;
        end
        SHUFFLE: begin
          deck_q[i_q] <= deck_q[j];
          deck_q[j]   <= deck_q[i_q];
          i_q         <= i_q - 6'd1;
          if (i_q == 6'd1) begin
            state_q     <= STREAM;
            load_flag_q <= 1'b1;
            k_q         <= 6'd0;
            hold_cnt_q  <= 4'd0;
          end
        end
        STREAM: begin
          // k reaches 52 only once the last card has completed its full hold window.
          if (hold_cnt_q == 4'd0 && k_q == 6'd52) begin
            state_q     <= DONE;
            load_flag_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            if (hold_cnt_q == 4'd0) begin
              card_q        <= deck_q[k_q];
              card_strobe_q <= 1'b1;
            end
            if (hold_cnt_q == HOLD_LAST) begin
              hold_cnt_q <= 4'd0;
              k_q        <= k_q + 6'd1;
            end else begin
              hold_cnt_q <= hold_cnt_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ld_if.load_flag   = load_flag_q;
  assign ld_if.card        = card_q;
  assign ld_if.card_strobe = card_strobe_q;
  assign ld_if.busy        = busy_q;
  assign ld_if.done        = done_q;

endmodule

// File: tb/tb_deck_shuffler.sv
// Bench for deck_shuffler: four parameterisations, reference shuffle model, timing and reset checks.
module tb_deck_shuffler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  deck_shuffler_if bus0 ();
  deck_shuffler_if bus1 ();
  deck_shuffler_if bus2 ();
  deck_shuffler_if bus3 ();

  deck_shuffler #(.SEED(16'hACE1), .HOLD(2))  u0 (.clk(clk), .rst(rst), .ld_if(bus0));
  deck_shuffler #(.SEED(16'h0000), .HOLD(1))  u1 (.clk(clk), .rst(rst), .ld_if(bus1));
  deck_shuffler #(.SEED(16'h0001), .HOLD(1))  u2 (.clk(clk), .rst(rst), .ld_if(bus2));
  deck_shuffler #(.SEED(16'h1234), .HOLD(15)) u3 (.clk(clk), .rst(rst), .ld_if(bus3));

  logic       sf [4];
  logic       lf [4];
  logic       cs [4];
  logic       bz [4];
  logic       dn [4];
  logic [5:0] cd [4];

  assign bus0.shuffle_flag = sf[0];
  assign bus1.shuffle_flag = sf[1];
  assign bus2.shuffle_flag = sf[2];
  assign bus3.shuffle_flag = sf[3];
  assign lf[0] = bus0.load_flag;   assign cs[0] = bus0.card_strobe;
  assign bz[0] = bus0.busy;        assign dn[0] = bus0.done;   assign cd[0] = bus0.card;
  assign lf[1] = bus1.load_flag;   assign cs[1] = bus1.card_strobe;
  assign bz[1] = bus1.busy;        assign dn[1] = bus1.done;   assign cd[1] = bus1.card;
  assign lf[2] = bus2.load_flag;   assign cs[2] = bus2.card_strobe;
  assign bz[2] = bus2.busy;        assign dn[2] = bus2.done;   assign cd[2] = bus2.card;
  assign lf[3] = bus3.load_flag;   assign cs[3] = bus3.card_strobe;
  assign bz[3] = bus3.busy;        assign dn[3] = bus3.done;   assign cd[3] = bus3.card;

  // Clock edges since reset release; edge e uses the LFSR value stepped e-1 times from the seed.
  int ecnt;
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  int         checks = 0;
  int         failures = 0;
  int         e0;
  logic [5:0] exp_seq [52];
  logic [5:0] got [52];

  function automatic logic [15:0] seed_of(input int d);
    case (d)
      0:       return 16'hACE1;
      1:       return 16'h0000;
      2:       return 16'h0001;
      default: return 16'h1234;
    endcase
  endfunction

  function automatic int hold_of(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      2:       return 1;
      default: return 15;
    endcase
  endfunction

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  task automatic build_model(input logic [15:0] seed, input int start_edge);
    logic [15:0] l;
    int          j;
    logic [5:0]  tmp;
    l = (seed == 16'h0000) ? 16'h0001 : seed;
    for (int e = 0; e < start_edge + 1; e++) l = lstep(l);
    for (int n = 0; n < 52; n++) exp_seq[n] = 6'(n);
    for (int i = 51; i >= 1; i--) begin
      j = (int'(l) * (i + 1)) / 65536;
      tmp = exp_seq[i];
      exp_seq[i] = exp_seq[j];
      exp_seq[j] = tmp;
      l = lstep(l);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < 4; d++) sf[d] = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask

  // abort_mode: 0 full run, 1 reset while SHUFFLE has i == 30, 2 reset right after the 20th strobe.
  task automatic run(input int d, input int abort_mode, input bit pulse);
    int         h, t, nstb, first_load, done_t, gap_bad, stable_bad, limit;
    int         mism, dup, missing, extra, done_drop;
    logic [5:0] last;
    bit         seen [64];
    bit         stop;
    h = hold_of(d);
    sf[d] = 1'b0;
    @(posedge clk); #1;
    sf[d] = 1'b1;
    @(posedge clk); #1;
    e0 = ecnt;
    build_model(seed_of(d), e0);
    chk("busy_after_start", bz[d], 1);
    chk("done_after_start", dn[d], 0);
    nstb = 0; first_load = -1; done_t = -1; gap_bad = 0; stable_bad = 0;
    last = 6'd63; stop = 1'b0; t = 0;
    limit = 53 + 52 * h + 10;
    while (!stop) begin
      if (pulse) begin
        if (t == 20 || t == 53 + 10 * h) sf[d] = 1'b0;
        if (t == 21 || t == 54 + 10 * h) sf[d] = 1'b1;
      end
      if (lf[d] && first_load < 0) first_load = t;
      if (t == 52) chk("card_before_first_strobe", cd[d], 63);
      if (cs[d]) begin
        if (nstb < 52) got[nstb] = cd[d];
        if (t != 53 + nstb * h) gap_bad++;
        nstb++;
        last = cd[d];
      end else if (nstb > 0 && cd[d] !== last) begin
        stable_bad++;
      end
      if (dn[d] && done_t < 0) begin
        done_t = t;
        chk("load_low_at_done", lf[d], 0);
        chk("busy_low_at_done", bz[d], 0);
      end
      if (abort_mode == 1 && t == 22) begin
        chk("busy_mid_shuffle", bz[d], 1);
        rst = 1'b1; #1;
        chk("rst_shuffle_card", cd[d], 63);
        chk("rst_shuffle_busy", bz[d], 0);
        chk("rst_shuffle_load", lf[d], 0);
        stop = 1'b1;
      end else if (abort_mode == 2 && cs[d] && nstb == 20) begin
        chk("load_before_rst", lf[d], 1);
        rst = 1'b1; #1;
        chk("rst_stream_load", lf[d], 0);
        chk("rst_stream_card", cd[d], 63);
        chk("rst_stream_busy", bz[d], 0);
        stop = 1'b1;
      end else if (done_t >= 0 || t >= limit) begin
        stop = 1'b1;
      end else begin
        @(posedge clk); #1;
        t++;
      end
    end
    if (abort_mode == 0) begin
      chk("load_rise_cycle", first_load, 52);
      chk("done_cycle", done_t, 53 + 52 * h);
      chk("strobe_count", nstb, 52);
      chk("strobe_spacing_errors", gap_bad, 0);
      mism = 0; dup = 0; missing = 0;
      for (int n = 0; n < 64; n++) seen[n] = 1'b0;
      for (int n = 0; n < 52; n++) begin
        if (got[n] !== exp_seq[n]) mism++;
        if (seen[got[n]]) dup++;
        seen[got[n]] = 1'b1;
      end
      for (int n = 0; n < 52; n++) if (!seen[n]) missing++;
      chk("model_sequence_mismatches", mism, 0);
      chk("duplicate_cards", dup, 0);
      chk("missing_cards", missing, 0);
      extra = 0; done_drop = 0;
      for (int c = 0; c < 100; c++) begin
        @(posedge clk); #1;
        if (cs[d]) extra++;
        if (!dn[d] || bz[d]) done_drop++;
        if (cd[d] !== last) stable_bad++;
      end
      chk("strobes_while_flag_high", extra, 0);
      chk("done_not_held", done_drop, 0);
      chk("card_unstable", stable_bad, 0);
    end
  endtask

  initial begin
    int         d0, diff, bad;
    logic [5:0] seq_a [52];
    rst = 1'b0;
    for (int d = 0; d < 4; d++) sf[d] = 1'b0;
    #3 rst = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) begin
      chk("reset_load_flag", lf[d], 0);
      chk("reset_card", cd[d], 63);
      chk("reset_strobe", cs[d], 0);
      chk("reset_busy", bz[d], 0);
      chk("reset_done", dn[d], 0);
    end
    idle(3);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 4; d++)
        if (cs[d] || lf[d] || bz[d] || dn[d] || cd[d] !== 6'd63) bad++;
    end
    chk("idle_activity", bad, 0);

    d0 = $urandom_range(0, 300);
    do_reset(); idle(d0); run(0, 0, 1'b0);
    seq_a = got;
    do_reset(); idle(d0); run(0, 0, 1'b0);
    diff = 0;
    for (int n = 0; n < 52; n++) if (got[n] !== seq_a[n]) diff++;
    chk("same_start_same_sequence", diff, 0);
    do_reset(); idle(d0 + 1); run(0, 0, 1'b0);
    diff = 0;
    for (int n = 0; n < 52; n++) if (got[n] !== seq_a[n]) diff++;
    chk("delayed_start_changes_sequence", (diff != 0), 1);

    d0 = $urandom_range(0, 300);
    do_reset(); idle(d0); run(1, 0, 1'b0);
    seq_a = got;
    do_reset(); idle(d0); run(2, 0, 1'b0);
    diff = 0;
    for (int n = 0; n < 52; n++) if (got[n] !== seq_a[n]) diff++;
    chk("seed0_equals_seed1", diff, 0);

    do_reset(); idle($urandom_range(0, 50)); run(3, 0, 1'b0);

    do_reset(); idle($urandom_range(0, 50)); run(0, 0, 1'b1);
    run(0, 0, 1'b0);

    do_reset(); idle($urandom_range(0, 50)); run(0, 1, 1'b0);
    do_reset(); idle($urandom_range(0, 50)); run(0, 2, 1'b0);
    do_reset(); idle($urandom_range(0, 50)); run(0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/deck_shuffler.md
# deck_shuffler

- Produces a uniformly shuffled 52-card deck (card codes 0–51) and streams it, one card at a time, to the blackjack game controller.
- It is the source end of the controller's load interface: the controller raises `shuffle_flag`, then collects cards while `load_flag` is high.
- Randomness comes from a free-running LFSR, so the permutation depends on when the request arrives.
- Shuffling uses a register-array Fisher–Yates algorithm that performs one swap per cycle.

## Interface

- `SEED`, default 16'hACE1: LFSR reset value. If it is 0, the LFSR loads 16'h0001 instead.
- `HOLD`, default 2: cycles each card is presented on `card`. Legal range is 1–15.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `shuffle_flag` in 1: shuffle request. Only its rising edge is significant; the level may stay high indefinitely.
- `load_flag` out 1: high while the stream is in progress (STREAM state).
- `card` out 6: current card code 0–51. It reads 6'd63 when no card has been presented.
- `card_strobe` out 1: one-cycle pulse on the first cycle each new `card` value is valid.
- `busy` out 1: high in INIT, SHUFFLE and STREAM.
- `done` out 1: high in DONE, after all 52 cards have been streamed.

## Operation

- **Storage:** `deck[0:51]`, 52 × 6-bit flops.
- **LFSR:** 16-bit Galois LFSR, mask 16'hB400. It shifts every cycle in every state, starting from reset.
- **Edge detect:** `shuffle_flag` is registered as `sf_q`. A rising edge (`start`) is `shuffle_flag & ~sf_q`.
- **States:**
  - IDLE → INIT on `start`.
  - INIT: in one cycle, `deck[n] <= n` for all n, and `i <= 51`. Next state is SHUFFLE.
  - SHUFFLE: compute `j = (lfsr * (i+1)) >> 16`, a 16×6 product taking bits [21:16], so 0 ≤ j ≤ i. Swap `deck[i]` and `deck[j]` in the same cycle; j == i is a no-op. Then `i <= i-1`. After the swap with i == 1, go to STREAM with `k <= 0` and `hold_cnt <= 0`.
  - STREAM:
    - `card <= deck[k]` when `hold_cnt == 0`.
    - `hold_cnt` counts 0..HOLD-1. On wrap, `k` increments.
    - After card k = 51 has been held HOLD cycles, go to DONE.
  - DONE: `card` holds its last value and the `deck` contents are retained. Go to INIT on `start`.
- **Ignored requests:** `start` is ignored in INIT, SHUFFLE and STREAM. A falling edge of `shuffle_flag` never aborts an operation.
- **Card sequence guarantee:** the 52 values presented form a permutation of 0..51. Consecutive values always differ, so a consumer that latches on value change sees every card exactly once.
- **Reset:** asynchronous and effective in any state, including mid-SHUFFLE and mid-STREAM. The block returns to IDLE and discards any partial deck.

## Timing

- **Reset values:**
  - `load_flag` = 0, `card` = 6'd63, `card_strobe` = 0, `busy` = 0, `done` = 0.
  - `lfsr` = SEED, `sf_q` = 0, state = IDLE.
- **Start:** if edge E0 samples `start` = 1, the state is INIT after E0, and `busy` rises in that cycle.
- **Shuffle phase:** one cycle of INIT plus 51 cycles of SHUFFLE.
- **First card:** after E0 + 52, the state is STREAM with `load_flag` = 1. `card` = `deck[0]` and `card_strobe` = 1 after E0 + 53. `card` holds 6'd63 for the first STREAM cycle, while `load_flag` is already 1.
- **Card rate:**
  - Card k is valid for HOLD cycles, starting after edge E0 + 53 + k·HOLD.
  - `card_strobe` is high for exactly 1 cycle per card.
  - There are exactly 52 strobes per shuffle.
- **Completion:**
  - `load_flag` falls, `done` rises and `busy` falls together, one edge after the final card's last hold cycle.
  - Total time from E0 to `done` = 53 + 52·HOLD cycles.
- **`done` lifetime:** stays high until the next `start` or `rst`. The `start` edge drops `done` and raises `busy` on the same edge.
- **Back-to-back requests:** `shuffle_flag` held high from reset triggers exactly one shuffle. A new shuffle needs `shuffle_flag` low for ≥1 sampled edge and then high again.

## Test plan

- **Reset values:** assert `rst` mid-cycle with `shuffle_flag` = 0. Required: all outputs at reset values, `card` = 63, and no strobes for 100 cycles.
- **Full shuffle, defaults:** SEED = 16'hACE1, HOLD = 2; raise `shuffle_flag` and hold it high. Required:
  - `load_flag` rises 52 cycles after `start` is sampled.
  - 52 strobes occur, 2 cycles apart.
  - The collected cards form a permutation of 0..51 with no repeats.
  - `done` rises 157 cycles after `start`.
  - No second shuffle occurs while `shuffle_flag` stays high.
- **Determinism and LFSR dependence:**
  - Same SEED with the `start` edge at the same cycle after reset: the two sequences must be identical.
  - Delaying `start` by 1 cycle must change the sequence.
  - SEED = 0 behaves exactly as SEED = 1.
- **HOLD = 1 and HOLD = 15:**
  - Strobes are 1 and 15 cycles apart respectively.
  - `card` is stable between strobes.
  - `done` arrives at 105 and 833 cycles respectively.
- **Ignored requests and restart:**
  - Pulse `shuffle_flag` low→high during SHUFFLE and again during STREAM. Required: no restart, and the strobe count is still 52.
  - After `done`, toggle `shuffle_flag`. Required: a second complete permutation follows.
- **Reset mid-operation:**
  - Assert `rst` at SHUFFLE i = 30. Required: immediate IDLE with `card` = 63.
  - Assert `rst` after the 20th strobe. Required: `load_flag` drops immediately and a following `start` yields a full 52-card stream.
